// File: rtl/fre_pkg.sv
// fre_pkg: shared FSM state encodings, mode codes and default counter width
package fre_pkg;
  localparam int CNT_W_DEF = 32;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] GATE = 3'd1;
  localparam logic [2:0] ARM  = 3'd2;
  localparam logic [2:0] MEAS = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic MODE_GATE   = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;
endpackage

// File: rtl/fin_edge_sync.sv
// fin_edge_sync: 2-flop synchroniser plus edge register giving a one-cycle rising-edge pulse
// sys_count_clk/rst_n: clock and async active-low reset; async_in: raw pin; rise: edge pulse
module fin_edge_sync (
  input  logic sys_count_clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], async_in};
  always_ff @(posedge sys_count_clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/fre_measure_ctrl.sv
// fre_measure_ctrl: auto-ranging sequencer, gate-time edge count with fallback to period measurement
// in: sys_count_clk, rst_n (async low), f_in, start, continuous, abort
// out: busy, mode (0 gate/1 period), result, result_valid (1-cycle), timeout
module fre_measure_ctrl
  import fre_pkg::*;
#(
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned GATE_CYCLES    = 50000000,
  parameter int unsigned THRESH_EDGES   = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic             sys_count_clk,
  input  logic             rst_n,
  input  logic             f_in,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  output logic             busy,
  output logic             mode,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             timeout
);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(THRESH_EDGES);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction
  logic             rise;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] gate_q, gate_d, edges_q, edges_d, tmo_q, tmo_d, per_q, per_d;
  logic [CNT_W-1:0] edges_now, result_q, result_d;
  logic             mode_q, mode_d, timeout_q, timeout_d;
  fin_edge_sync u_sync (
    .sys_count_clk(sys_count_clk),
    .rst_n        (rst_n),
    .async_in     (f_in),
    .rise         (rise)
  );
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    edges_d   = edges_q;
    tmo_d     = tmo_q;
    per_d     = per_q;
    result_d  = result_q;
    mode_d    = mode_q;
    timeout_d = timeout_q;
    edges_now = rise ? sat_inc(edges_q) : edges_q;
    case (state_q)
      IDLE: state_d = start ? GATE : IDLE;
      GATE: begin
        gate_d  = sat_inc(gate_q);
        edges_d = edges_now;
        if (gate_q >= GATE_LAST) begin
          state_d = (edges_now >= THRESH) ? DONE : ARM;
          if (edges_now >= THRESH) begin
            result_d  = edges_now;
            mode_d    = MODE_GATE;
            timeout_d = 1'b0;
          end
        end
      end
      ARM, MEAS: begin
        tmo_d = sat_inc(tmo_q);
        per_d = (state_q == ARM) ? CNT_W'(1) : sat_inc(per_q);
        // an edge in the timeout cycle takes precedence over the timeout
        if (rise) begin
          state_d = (state_q == ARM) ? MEAS : DONE;
          if (state_q == MEAS) begin
            result_d  = per_q;
            mode_d    = MODE_PERIOD;
            timeout_d = 1'b0;
          end
        end else if (tmo_q >= TMO_LAST) begin
          state_d   = DONE;
          result_d  = '0;
          mode_d    = MODE_PERIOD;
          timeout_d = 1'b1;
        end
      end
      DONE:    state_d = continuous ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      result_d  = result_q;
      mode_d    = mode_q;
      timeout_d = timeout_q;
    end
    // counters restart from zero for every new gate window
    if (state_d == IDLE || state_d == DONE) begin
      gate_d  = '0;
      edges_d = '0;
      tmo_d   = '0;
      per_d   = '0;
    end
  end
  always_ff @(posedge sys_count_clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      edges_q   <= '0;
      tmo_q     <= '0;
      per_q     <= '0;
      result_q  <= '0;
      mode_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      edges_q   <= edges_d;
      tmo_q     <= tmo_d;
      per_q     <= per_d;
      result_q  <= result_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
    end
  assign busy         = state_q != IDLE;
  assign result_valid = state_q == DONE;
  assign result       = result_q;
  assign mode         = mode_q;
  assign timeout      = timeout_q;
endmodule

// File: tb/tb_fre_measure_ctrl.sv
// tb_fre_measure_ctrl: randomized self-checking bench against an edge-time reference model
module tb_fre_measure_ctrl;
  localparam int G = 100, TH = 5, TO = 400, LAT = 3;
  logic clk = 0, rst_n = 0, f_in = 0, start = 0, continuous = 0, abort = 0;
  logic busy, mode, result_valid, timeout;
  logic [31:0] result;
  int cyc = 0, per = 0, ph = 0, checks = 0, errors = 0;
  fre_measure_ctrl #(.CNT_W(32), .GATE_CYCLES(G), .THRESH_EDGES(TH), .TIMEOUT_CYCLES(TO)) dut (
    .sys_count_clk(clk), .rst_n(rst_n), .f_in(f_in), .start(start), .continuous(continuous),
    .abort(abort), .busy(busy), .mode(mode), .result(result), .result_valid(result_valid),
    .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) f_in = (per == 0) ? 1'b0 : (((cyc + per - ph) % per) < per / 2);
  // pin rises after posedge p (p = ph mod per); the FSM consumes it LAT edges later
  function automatic bit is_edge(input int e);
    int p;
    p = e - LAT;
    return (per == 0 || p < 0) ? 1'b0 : (((p + per - ph) % per) == 0);
  endfunction
  // start consumed at posedge s: gate window s+1..s+G, period window s+G+1..s+G+TO
  function automatic void model(input int s, output int d, output int r, output int m, output int t);
    int g, e1, e2, dl;
    g = 0; e1 = -1; e2 = -1;
    for (int e = s + 1; e <= s + G; e++) if (is_edge(e)) g++;
    if (g >= TH) begin d = s + G; r = g; m = 0; t = 0; return; end
    for (int e = s + G + 1; e <= s + G + TO && e1 < 0; e++) if (is_edge(e)) e1 = e;
    if (e1 < 0) begin d = s + G + TO; r = 0; m = 1; t = 1; return; end
    dl = (e1 + 1 > s + G + TO) ? e1 + 1 : s + G + TO;
    for (int e = e1 + 1; e <= dl && e2 < 0; e++) if (is_edge(e)) e2 = e;
    if (e2 < 0) begin d = dl; r = 0; m = 1; t = 1; end
    else begin d = e2; r = e2 - e1; m = 1; t = 0; end
  endfunction
  task automatic set_sig(input int p, input int f);
    per = p; ph = f;
    repeat (5) @(negedge clk);
  endtask
  task automatic start_pulse(output int s);
    @(negedge clk); start = 1; s = cyc + 1;
    @(negedge clk); start = 0;
  endtask
  task automatic wait_valid(output int d, output int r, output int m, output int t);
    d = -1; r = 0; m = 0; t = 0;
    for (int i = 0; i < 2000 && d < 0; i++) begin
      @(negedge clk);
      if (result_valid) begin d = cyc; r = int'(result); m = int'(mode); t = int'(timeout); end
    end
  endtask
  task automatic count_valid(input int n, output int c);
    c = 0;
    repeat (n) begin @(negedge clk); if (result_valid) c++; end
  endtask
  task automatic test_reset;
    #1;
    checks++; if (busy !== 0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (mode !== 0) begin errors++; $display("FAIL rst_mode got %0b want 0", mode); end
    checks++; if (result !== 0) begin errors++; $display("FAIL rst_result got %0d want 0", result); end
    checks++; if (result_valid !== 0) begin errors++; $display("FAIL rst_valid got %0b want 0", result_valid); end
    checks++; if (timeout !== 0) begin errors++; $display("FAIL rst_timeout got %0b want 0", timeout); end
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_gate;
    int s, d, r, m, t, ed, er, em, et;
    set_sig(10, 3); start_pulse(s); wait_valid(d, r, m, t); model(s, ed, er, em, et);
    checks++; if (d !== ed) begin errors++; $display("FAIL gate_time got %0d want %0d", d, ed); end
    checks++; if (r !== 10 || er !== 10) begin errors++; $display("FAIL gate_result got %0d want 10", r); end
    checks++; if (m !== 0) begin errors++; $display("FAIL gate_mode got %0d want 0", m); end
    checks++; if (t !== 0) begin errors++; $display("FAIL gate_timeout got %0d want 0", t); end
    @(negedge clk);
    checks++; if (result_valid !== 0) begin errors++; $display("FAIL gate_pulse_len got %0b want 0", result_valid); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL gate_busy_after got %0b want 0", busy); end
  endtask
  task automatic test_period;
    int s, d, r, m, t, ed, er, em, et;
    set_sig(50, 7); start_pulse(s); wait_valid(d, r, m, t); model(s, ed, er, em, et);
    checks++; if (d !== ed) begin errors++; $display("FAIL per_time got %0d want %0d", d, ed); end
    checks++; if (r !== 50) begin errors++; $display("FAIL per_result got %0d want 50", r); end
    checks++; if (m !== 1) begin errors++; $display("FAIL per_mode got %0d want 1", m); end
    checks++; if (t !== 0) begin errors++; $display("FAIL per_timeout got %0d want 0", t); end
  endtask
  task automatic test_timeout;
    int s, d, r, m, t;
    set_sig(0, 0); start_pulse(s); wait_valid(d, r, m, t);
    checks++; if (d !== s + G + TO) begin errors++; $display("FAIL tmo_time got %0d want %0d", d, s + G + TO); end
    checks++; if (r !== 0 || m !== 1 || t !== 1) begin errors++; $display("FAIL tmo_fields got r=%0d m=%0d t=%0d want 0 1 1", r, m, t); end
    set_sig(10, 0); start_pulse(s); wait_valid(d, r, m, t);
    checks++; if (t !== 0 || r !== 10) begin errors++; $display("FAIL tmo_clear got t=%0d r=%0d want 0 10", t, r); end
  endtask
  task automatic test_continuous;
    int s, d1, d2, d3, r1, r2, r3, m, t, c;
    set_sig(10, 1); continuous = 1; start_pulse(s);
    wait_valid(d1, r1, m, t); wait_valid(d2, r2, m, t);
    @(negedge clk); continuous = 0;
    wait_valid(d3, r3, m, t);
    checks++; if (d1 !== s + G) begin errors++; $display("FAIL cont_first got %0d want %0d", d1, s + G); end
    checks++; if (d2 - d1 !== G + 1 || d3 - d2 !== G + 1) begin errors++; $display("FAIL cont_spacing got %0d %0d want %0d", d2 - d1, d3 - d2, G + 1); end
    checks++; if (r1 !== 10 || r2 !== 10 || r3 !== 10) begin errors++; $display("FAIL cont_result got %0d %0d %0d want 10", r1, r2, r3); end
    @(negedge clk);
    checks++; if (busy !== 0) begin errors++; $display("FAIL cont_stop_busy got %0b want 0", busy); end
    count_valid(200, c);
    checks++; if (c !== 0) begin errors++; $display("FAIL cont_stop_valid got %0d want 0", c); end
  endtask
  task automatic test_start_ignored;
    int s, s2, d, r, m, t, c;
    set_sig(10, 2); start_pulse(s); repeat (30) @(negedge clk); start_pulse(s2);
    wait_valid(d, r, m, t);
    checks++; if (d !== s + G || r !== 10) begin errors++; $display("FAIL restart_ign got d=%0d r=%0d want %0d 10", d, r, s + G); end
    count_valid(150, c);
    checks++; if (c !== 0 || busy !== 0) begin errors++; $display("FAIL restart_extra got %0d valids busy=%0b want 0 0", c, busy); end
  endtask
  task automatic test_abort;
    int s, e1, c;
    set_sig(50, 4); start_pulse(s);
    e1 = -1;
    for (int e = s + G + 1; e <= s + G + TO && e1 < 0; e++) if (is_edge(e)) e1 = e;
    while (cyc < e1 + 4) @(negedge clk);
    abort = 1; @(negedge clk); abort = 0;
    checks++; if (busy !== 0 || result_valid !== 0) begin errors++; $display("FAIL abort_idle got busy=%0b valid=%0b want 0 0", busy, result_valid); end
    count_valid(600, c);
    checks++; if (c !== 0) begin errors++; $display("FAIL abort_valid got %0d want 0", c); end
    checks++; if (result !== 10 || mode !== 0 || timeout !== 0) begin errors++; $display("FAIL abort_hold got r=%0d m=%0b t=%0b want 10 0 0", result, mode, timeout); end
  endtask
  task automatic test_random;
    int s, d, r, m, t, ed, er, em, et, k, p;
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 3);
      p = (k == 0) ? 0 : (k == 1) ? $urandom_range(2, 20) : (k == 2) ? $urandom_range(21, 120) : $urandom_range(121, 300);
      set_sig(p, (p == 0) ? 0 : $urandom_range(0, p - 1));
      start_pulse(s); wait_valid(d, r, m, t); model(s, ed, er, em, et);
      checks++; if (d !== ed) begin errors++; $display("FAIL rnd_time per=%0d got %0d want %0d", p, d, ed); end
      checks++; if (r !== er) begin errors++; $display("FAIL rnd_result per=%0d got %0d want %0d", p, r, er); end
      checks++; if (m !== em || t !== et) begin errors++; $display("FAIL rnd_flags per=%0d got m=%0d t=%0d want %0d %0d", p, m, t, em, et); end
    end
  endtask
  task automatic test_async_reset;
    int s, d, r, m, t, ed, er, em, et;
    set_sig(10, 5); start_pulse(s); repeat (40) @(negedge clk);
    @(posedge clk); #2 rst_n = 0; #1;
    checks++; if (busy !== 0 || result_valid !== 0) begin errors++; $display("FAIL arst_ctrl got busy=%0b valid=%0b want 0 0", busy, result_valid); end
    checks++; if (result !== 0 || mode !== 0 || timeout !== 0) begin errors++; $display("FAIL arst_out got r=%0d m=%0b t=%0b want 0 0 0", result, mode, timeout); end
    @(negedge clk); rst_n = 1;
    start_pulse(s); wait_valid(d, r, m, t); model(s, ed, er, em, et);
    checks++; if (d !== ed || r !== 10 || m !== 0 || t !== 0) begin errors++; $display("FAIL arst_fresh got d=%0d r=%0d want %0d 10", d, r, ed); end
  endtask
  initial begin
    test_reset;
    test_gate;
    test_period;
    test_timeout;
    test_continuous;
    test_start_ignored;
    test_abort;
    test_random;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
